counter_32: RTL and testbench

COUNTER_32 -- requirements
Module: counter_32

---
 rtl/counter_32_pkg.sv | 10 +
 rtl/tff_sync.sv | 21 ++
 rtl/counter_32.sv | 41 ++++
 tb/tb_counter_32.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/counter_32_pkg.sv
// Shared constants and types for the counter_32 ripple-free synchronous counter.
// The optional terminal-count output is enabled by defining COUNTER_32_TC_EN.
package counter_32_pkg;

  localparam int unsigned COUNTER_32_WIDTH = 5;
  localparam int unsigned COUNTER_32_MAX   = (1 << COUNTER_32_WIDTH) - 1;

  typedef logic [COUNTER_32_WIDTH-1:0] count_t;

endpackage

// File: rtl/tff_sync.sv
// T flip-flop with synchronous active-high clear; one bit of the counter_32 chain.
module tff_sync (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_32.sv
// Modulo-2**WIDTH synchronous up-counter built from T flip-flops and an AND-carry chain.
// Define COUNTER_32_TC_EN to add the combinational terminal-count output tc.
module counter_32
  import counter_32_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_32_WIDTH
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ena,
  output logic [WIDTH-1:0] out
`ifdef COUNTER_32_TC_EN
  ,
  output logic             tc
`endif
);

  // carry[i] is high when bit i should toggle: ena and every lower bit set.
  logic [WIDTH-1:0] carry;

  assign carry[0] = ena;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi > 0) begin : g_carry
      assign carry[gi] = carry[gi-1] & out[gi-1];
    end

    tff_sync u_tff (
      .clk (clk),
      .clr (clrn),
      .t   (carry[gi]),
      .q   (out[gi])
    );
  end

`ifdef COUNTER_32_TC_EN
  // All ones with ena and no clear: the next edge wraps to zero.
  assign tc = carry[WIDTH-1] & out[WIDTH-1] & ~clrn;
`endif

endmodule

// File: tb/tb_counter_32.sv
// Scoreboard bench for counter_32: driver queues expected results, a monitor checks each edge.
module tb_counter_32;
  import counter_32_pkg::*;

  logic   clk;
  logic   clrn;
  logic   ena;
  count_t out;
`ifdef COUNTER_32_TC_EN
  logic   tc;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    count_t out;
    logic   tc;
  } exp_t;

  exp_t exp_q[$];

  counter_32 #(.WIDTH(COUNTER_32_WIDTH)) dut (
    .clk  (clk),
    .clrn (clrn),
    .ena  (ena),
    .out  (out)
`ifdef COUNTER_32_TC_EN
    ,
    .tc   (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string name, input count_t exp);
    checks++;
    if (out !== exp) begin
      failures++;
      $display("FAIL %s: out=%0d required=%0d at %0t", name, out, exp, $time);
    end
  endtask

`ifdef COUNTER_32_TC_EN
  task automatic check_tc(input string name, input logic exp);
    checks++;
    if (tc !== exp) begin
      failures++;
      $display("FAIL %s: tc=%b required=%b at %0t", name, tc, exp, $time);
    end
  endtask
`endif

  // Monitor: every rising edge presents a new count; compare against the oldest expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_out("edge_out", e.out);
`ifdef COUNTER_32_TC_EN
      check_tc("edge_tc", e.tc);
`endif
    end
  end

  // Drive one edge worth of inputs; exp_out is the hand-computed count after the edge,
  // pre_tc / post_tc the terminal-count flag before and after that edge.
  task automatic step(input logic c, input logic e, input int exp_out,
                      input logic pre_tc, input logic post_tc);
    exp_t x;
    @(negedge clk);
    clrn = c;
    ena  = e;
    #1;
`ifdef COUNTER_32_TC_EN
    check_tc("pre_edge_tc", pre_tc);
`endif
    x.out = count_t'(exp_out);
    x.tc  = post_tc;
    exp_q.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    clrn = 1'b1;
    ena  = 1'b0;

    // Held in reset with ena low: stays at zero.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Full wrap: 1..31 then 0 after edge 32; tc high only while out is 31.
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, 1'b1, i % 32, (i == 32), (i == 31));
    end

    // Count to 7, freeze two edges, resume to 8.
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, i, 1'b0, 1'b0);
    step(1'b0, 1'b0, 7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 7, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8, 1'b0, 1'b0);

    // Up to 20, then clear dominates enable, then resume from 0.
    for (int i = 9; i <= 20; i++) step(1'b0, 1'b1, i, 1'b0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1, 1'b0, 1'b0);

    // Toggle clrn and ena with no edge in between: out must not move.
    @(negedge clk);
    clrn = 1'b1;
    #1 check_out("toggle_clrn", 5'd1);
    ena = 1'b1;
    #1 check_out("toggle_both", 5'd1);
    clrn = 1'b0;
    #1 check_out("toggle_ena", 5'd1);
    ena = 1'b0;
    #1 check_out("toggle_idle", 5'd1);
    x.out = 5'd1;
    x.tc  = 1'b0;
    exp_q.push_back(x);

    // Long freeze then resume.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2, 1'b0, 1'b0);

    // Let the monitor drain, then confirm nothing was left unchecked.
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
